// File: rtl/pll_drp_pkg.sv
// Shared definitions for the PLL dynamic-reconfiguration controller:
// MD port opcodes, host command encodings, FSM states and lock qualification length.
package pll_drp_pkg;

    // Opcodes presented to the PLL on MDOPC
    localparam logic [1:0] MD_NOP   = 2'b00;
    localparam logic [1:0] MD_WRITE = 2'b01;
    localparam logic [1:0] MD_READ  = 2'b10;
    localparam logic [1:0] MD_ADDR  = 2'b11;

    // Host command encodings on req_op
    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_RELOCK = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // Synced lock must stay high this many consecutive clk cycles to count
    localparam int LOCK_QUAL_CYCLES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,      // waiting for the fall tick that launches the ADDR phase
        ST_DATA,      // ADDR on the bus; next fall tick launches WRITE/READ
        ST_TAIL,      // WRITE/READ on the bus; next fall tick returns to NOP
        ST_RDWAIT,    // counting read latency in mdclk rise ticks
        ST_RST,       // PLL reset asserted
        ST_LOCKWAIT,  // waiting for qualified lock or timeout
        ST_RESP       // single-cycle response strobe
    } state_t;

    // Commands that run a register access on the MD port
    function automatic logic op_uses_md(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/pll_lock_mon.sv
// PLL lock monitor: 2-flop synchronizer for the asynchronous lock input, a
// consecutive-high qualifier and a timeout counter active while the
// controller is waiting for lock.
module pll_lock_mon
    import pll_drp_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic arm,          // high while (re)entering PLL reset: forget any old lock
    input  logic en,           // high while waiting for lock
    input  logic pll_lock,     // raw, asynchronous
    output logic locked,
    output logic lock_ok,
    output logic lock_timeout
);

    localparam int QW = $clog2(LOCK_QUAL_CYCLES + 1);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic [QW-1:0] qual_cnt_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          locked_reg;
    logic          qualified;

    assign qualified    = (qual_cnt_reg == QW'(LOCK_QUAL_CYCLES));
    assign lock_ok      = en && qualified;
    assign lock_timeout = en && (to_cnt_reg == TW'(LOCK_TIMEOUT - 1));
    assign locked       = locked_reg;

    // Bring the raw lock into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pll_lock;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive synced-high cycles, saturating once qualified
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qual_cnt_reg <= '0;
        end else if (arm || !sync2_reg) begin
            qual_cnt_reg <= '0;
        end else if (!qualified) begin
            qual_cnt_reg <= qual_cnt_reg + 1'b1;
        end
    end

    // Timeout counter only runs while the controller waits for lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_reg <= '0;
        end else if (!en) begin
            to_cnt_reg <= '0;
        end else if (!lock_timeout) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    // Qualified lock status: set on qualification, dropped with the synced lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_reg <= 1'b0;
        end else if (arm || !sync2_reg) begin
            locked_reg <= 1'b0;
        end else if (lock_ok) begin
            locked_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/pll_drp_ctrl.sv
// PLL dynamic-reconfiguration sequencer. Accepts one host command at a time
// (register write, register read, relock), drives the PLL MD port from a
// locally divided mdclk and returns a single-cycle response.
// Optional build macro: PLL_DRP_VERIFY_EN -- every write is followed by an
// internal readback of the same address; the response carries the readback
// and flags a mismatch against the written data.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int MDCLK_DIV    = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RD_LAT       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       mdclk,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock,
    output logic       locked,
    output logic       busy
);

    localparam int DW = (MDCLK_DIV > 1) ? $clog2(MDCLK_DIV) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // Where a write goes once its data phase has been retired
`ifdef PLL_DRP_VERIFY_EN
    localparam state_t WRITE_DONE_STATE = ST_ADDR;
`else
    localparam state_t WRITE_DONE_STATE = ST_RESP;
`endif

    state_t        state_reg;
    state_t        state_next;

    logic [DW-1:0] div_cnt_reg;
    logic          mdclk_reg;
    logic          div_end;
    logic          fall_tick;
    logic          rise_tick;

    logic [1:0]    op_reg;
    logic [7:0]    addr_reg;
    logic [7:0]    wdata_reg;
    logic          verify_reg;

    logic [RW-1:0] rst_cnt_reg;
    logic [LW-1:0] rd_cnt_reg;
    logic          rd_last;

    logic [7:0]    res_rdata_reg;
    logic          res_err_reg;

    logic [1:0]    mdopc_reg;
    logic [1:0]    mdopc_next;
    logic [7:0]    mdwdi_reg;
    logic [7:0]    mdwdi_next;

    logic          ready_reg;
    logic          accept;
    logic          read_phase;

    logic          lock_ok;
    logic          lock_timeout;

    assign div_end   = (div_cnt_reg == DW'(MDCLK_DIV - 1));
    assign fall_tick = div_end && mdclk_reg;
    assign rise_tick = div_end && !mdclk_reg;

    assign accept     = req_valid && ready_reg;
    assign read_phase = (op_reg == OP_READ) || verify_reg;
    assign rd_last    = (rd_cnt_reg == LW'(RD_LAT - 1));

    assign req_ready = ready_reg;
    assign mdclk     = mdclk_reg;
    assign mdopc     = mdopc_reg;
    assign mdwdi     = mdwdi_reg;
    assign mdainc    = 1'b0;

    // Free-running mdclk divider; toggles every MDCLK_DIV clk cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
            mdclk_reg   <= 1'b0;
        end else if (div_end) begin
            div_cnt_reg <= '0;
            mdclk_reg   <= !mdclk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; MD phases advance only on mdclk fall ticks
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op_uses_md(req_op)) begin
                        state_next = ST_ADDR;
                    end else if (req_op == OP_RELOCK) begin
                        state_next = ST_RST;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (fall_tick) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_tick) begin
                    state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (fall_tick) begin
                    state_next = read_phase ? ST_RDWAIT : WRITE_DONE_STATE;
                end
            end
            ST_RDWAIT: begin
                if (rise_tick && rd_last) begin
                    state_next = ST_RESP;
                end
            end
            ST_RST: begin
                if (rst_cnt_reg == RW'(RST_CYCLES - 1)) begin
                    state_next = ST_LOCKWAIT;
                end
            end
            ST_LOCKWAIT: begin
                if (lock_ok || lock_timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: status strobes and the next MD bus values
    always_comb begin
        pll_reset  = (state_reg == ST_RST);
        rsp_valid  = (state_reg == ST_RESP);
        busy       = (state_reg != ST_IDLE);
        rsp_rdata  = rsp_valid ? res_rdata_reg : 8'h00;
        rsp_err    = rsp_valid && res_err_reg;
        mdopc_next = mdopc_reg;
        mdwdi_next = mdwdi_reg;
        if (fall_tick) begin
            unique case (state_reg)
                ST_ADDR: begin
                    mdopc_next = MD_ADDR;
                    mdwdi_next = addr_reg;
                end
                ST_DATA: begin
                    if (read_phase) begin
                        mdopc_next = MD_READ;
                        mdwdi_next = 8'h00;
                    end else begin
                        mdopc_next = MD_WRITE;
                        mdwdi_next = wdata_reg;
                    end
                end
                ST_TAIL: begin
                    mdopc_next = MD_NOP;
                    mdwdi_next = 8'h00;
                end
                default: begin
                    mdopc_next = MD_NOP;
                end
            endcase
        end
    end

    // MD bus registers; they only change together with an mdclk fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdopc_reg <= MD_NOP;
            mdwdi_reg <= 8'h00;
        end else begin
            mdopc_reg <= mdopc_next;
            mdwdi_reg <= mdwdi_next;
        end
    end

    // Ready is withheld for the first cycle out of reset and until after the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= (state_next == ST_IDLE);
        end
    end

    // Operand capture, phase counters and response payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg        <= OP_WRITE;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            rst_cnt_reg   <= '0;
            rd_cnt_reg    <= '0;
            res_rdata_reg <= 8'h00;
            res_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                op_reg        <= req_op;
                addr_reg      <= req_addr;
                wdata_reg     <= req_wdata;
                res_rdata_reg <= 8'h00;
                res_err_reg   <= (req_op == OP_RSVD);
            end

            if (state_reg == ST_RST) begin
                rst_cnt_reg <= rst_cnt_reg + 1'b1;
            end else begin
                rst_cnt_reg <= '0;
            end

            if (state_reg != ST_RDWAIT) begin
                rd_cnt_reg <= '0;
            end else if (rise_tick) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end

            if (state_reg == ST_RDWAIT && rise_tick && rd_last) begin
                res_rdata_reg <= mdrdo;
                res_err_reg   <= verify_reg && (mdrdo != wdata_reg);
            end

            if (state_reg == ST_LOCKWAIT && !lock_ok && lock_timeout) begin
                res_err_reg <= 1'b1;
            end
        end
    end

`ifdef PLL_DRP_VERIFY_EN
    // Mark the readback pass that follows a write's data phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            verify_reg <= 1'b0;
        end else if (state_reg == ST_RESP) begin
            verify_reg <= 1'b0;
        end else if (state_reg == ST_TAIL && fall_tick && op_reg == OP_WRITE) begin
            verify_reg <= 1'b1;
        end
    end
`else
    assign verify_reg = 1'b0;
`endif

    pll_lock_mon #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_mon (
        .clk          (clk),
        .reset        (reset),
        .arm          (state_next == ST_RST),
        .en           (state_reg == ST_LOCKWAIT),
        .pll_lock     (pll_lock),
        .locked       (locked),
        .lock_ok      (lock_ok),
        .lock_timeout (lock_timeout)
    );

endmodule
